uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
// - Shares one serial TX line and one baud-tick generator (baudrate block) between N byte requesters.
// - Picks requesters round-robin and serialises the chosen byte as 8N1, LSB first (8E1 with parity option).
// - Holds the baud generator in reset while idle; releases it at frame start so every frame is tick-aligned.
// - Sits between the internal byte producers and the UART pin; one baud tick = one bit time.
// PARAMETERS
// - N_REQ      4    number of requesters, 2..8
// - DATA_W     8    bits per frame payload (fixed at 8 in this release)
// PORTS
// - i_clk        in   1            system clock
// - i_rst_n      in   1            reset: asynchronous, active-low
// - i_req_valid  in   N_REQ        per-requester byte valid; must be held until ready
// - i_req_data   in   N_REQ*DATA_W per-requester byte; slice k = [k*8 +: 8]
// - o_req_ready  out  N_REQ        one-hot accept pulse; transfer when valid&ready
// - i_b_tick     in   1            bit-time tick from baudrate.o_b_tick
// - o_br_rst     out  1            drives baudrate.i_br_rst (sync, active-high)
// - o_tx         out  1            serial line, idle high
// - o_busy       out  1            high from accept through stop-bit end
// - o_grant_id   out  $clog2(N_REQ) index of requester currently being sent
// BEHAVIOUR
// - Reset (i_rst_n=0): o_tx=1, o_busy=0, o_req_ready=0, o_br_rst=1, o_grant_id=0, state=IDLE, rr pointer=N_REQ-1.
// - FSM: IDLE -> SYNC -> START -> DATA -> [PARITY] -> STOP -> IDLE.
// - IDLE: o_tx=1, o_br_rst=1. If any i_req_valid: grant first valid requester after the rr pointer (wrap N_REQ-1 -> 0).
//   o_req_ready[g]=1 combinationally this cycle only. Latch the byte and g, set the pointer to g, go to SYNC.
// - SYNC (1 cycle): o_br_rst=1, o_tx=0 (start bit begins). o_busy=1. Any i_b_tick is ignored.
// - START: o_br_rst=0, o_tx=0; on i_b_tick go to DATA with bit counter=0.
// - DATA: o_tx=shift[0]; on i_b_tick shift right and count+1. After the tick with count==7 go to PARITY/STOP.
// - STOP: o_tx=1; on i_b_tick go to IDLE. o_busy drops in that IDLE cycle.
// - o_br_rst=0 in START/DATA/PARITY/STOP only. Baud generator free-runs only inside a frame.
// - Minimum inter-frame gap: 1 IDLE cycle plus SYNC. A new grant may occur in the first IDLE cycle after STOP.
// - Valid dropped before grant: not an error. Arbitration is re-evaluated every IDLE cycle; no grant is held.
// - Valid/data changes during a frame: ignored; the latched byte is sent.
// - Reset mid-frame: line returns high asynchronously. The partial frame is abandoned and not retried.
// - All outputs registered except o_req_ready, which is combinational from IDLE state and i_req_valid.
// CONFIGURATION
// - Macro UART_TX_ARB_PARITY_EN.
// - Defined: PARITY state after DATA sends even parity (XOR of 8 data bits) for one tick; frame = 11 bits.
// - Undefined: no PARITY state, DATA -> STOP directly; frame = 10 bits. Port list is unchanged either way.
// STRUCTURE
// - uart_pkg: typedef enum logic [2:0] tx_state_t {IDLE,SYNC,START,DATA,PARITY,STOP}; localparams
//   UART_DATA_BITS=8, UART_IDLE_LVL=1'b1.
// - Sub-module rr_arbiter: N-way round-robin, inputs req/pointer, outputs one-hot grant + index.
//   Purely combinational; the pointer register lives here in uart_tx_arbiter.
// - Instantiates no baudrate itself; top level wires o_br_rst/i_b_tick to a baudrate instance.
// TESTING (bench instantiates baudrate with clk_speed=8, baudrate=1 -> 8-cycle bit)
// - Single req0 byte 8'hA5 -> o_tx: 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop), each bit
//   between consecutive i_b_tick; o_grant_id=0.
// - req0..req3 all valid with 8'h11,22,33,44 after reset -> frames sent in order 0,1,2,3.
//   Each o_req_ready is a single-cycle pulse.
// - req1 and req3 held valid continuously -> grants alternate 1,3,1,3. No requester is granted twice in a row.
// - Assert i_rst_n=0 during DATA bit 4 -> o_tx=1 the same cycle. After release, req2 pending -> req0 and req1
//   idle, so req2 is sent fully; the pointer restarts so priority is req0 first.
// - Tick forced high during SYNC (bench override) -> ignored; start bit still lasts one full tick period.
// - With UART_TX_ARB_PARITY_EN, byte 8'h07 -> parity bit 1, frame length 11 ticks.
//   Byte 8'h03 -> parity bit 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the round-robin UART transmitter.
// Optional even-parity bit is enabled by defining UART_TX_ARB_PARITY_EN.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_IDLE_LVL  = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way round-robin arbiter: grants the first request strictly
// after ptr_i (wrapping), returning a one-hot grant and its index.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    int cand;

    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = (int'(ptr_i) + i) % N_REQ;
            if (!any_o && req_i[cand]) begin
                any_o         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one 8N1 serial line between N_REQ byte producers, round-robin.
// Define UART_TX_ARB_PARITY_EN to append an even-parity bit (8E1).
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [N_REQ-1:0]           i_req_valid,
    input  logic [N_REQ*DATA_W-1:0]    i_req_data,
    output logic [N_REQ-1:0]           o_req_ready,
    input  logic                       i_b_tick,
    output logic                       o_br_rst,
    output logic                       o_tx,
    output logic                       o_busy,
    output logic [$clog2(N_REQ)-1:0]   o_grant_id
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(UART_DATA_BITS);

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  gid_q, gid_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              br_rst_q, br_rst_d;
`ifdef UART_TX_ARB_PARITY_EN
    logic              par_q, par_d;
`endif

    logic [N_REQ-1:0]  gnt;
    logic [IDX_W-1:0]  gnt_idx;
    logic              gnt_any;
    logic [DATA_W-1:0] gnt_byte;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req_i   (i_req_valid),
        .ptr_i   (ptr_q),
        .grant_o (gnt),
        .idx_o   (gnt_idx),
        .any_o   (gnt_any)
    );

    assign gnt_byte = i_req_data[int'(gnt_idx)*DATA_W +: DATA_W];

    // Accept is only offered while idle and out of reset.
    assign o_req_ready = (state_q == IDLE && i_rst_n) ? gnt : '0;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
`ifdef UART_TX_ARB_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    state_d = SYNC;
                    ptr_d   = gnt_idx;
                    gid_d   = gnt_idx;
                    shift_d = gnt_byte;
`ifdef UART_TX_ARB_PARITY_EN
                    par_d   = ^gnt_byte;
`endif
                end
            end
            SYNC:  state_d = START;
            START: begin
                if (i_b_tick) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                if (i_b_tick) begin
                    shift_d = shift_q >> 1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_ARB_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_ARB_PARITY_EN
            PARITY: if (i_b_tick) state_d = STOP;
`endif
            STOP:  if (i_b_tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they leave flops aligned to it.
        busy_d   = (state_d != IDLE);
        br_rst_d = (state_d == IDLE) || (state_d == SYNC);
        case (state_d)
            SYNC, START: tx_d = ~UART_IDLE_LVL;
            DATA:        tx_d = shift_d[0];
`ifdef UART_TX_ARB_PARITY_EN
            PARITY:      tx_d = par_d;
`endif
            default:     tx_d = UART_IDLE_LVL;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            ptr_q    <= IDX_W'(N_REQ - 1);
            gid_q    <= '0;
            tx_q     <= UART_IDLE_LVL;
            busy_q   <= 1'b0;
            br_rst_q <= 1'b1;
`ifdef UART_TX_ARB_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking updates so all state advances together on the edge.
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            gid_q    <= gid_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            br_rst_q <= br_rst_d;
`ifdef UART_TX_ARB_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    assign o_tx       = tx_q;
    assign o_busy     = busy_q;
    assign o_br_rst   = br_rst_q;
    assign o_grant_id = gid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised and directed bench for uart_tx_arbiter with a frame-level model
// and an 8-cycle-per-bit baud generator held in reset by o_br_rst.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
`ifdef UART_TX_ARB_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif
    localparam int FL   = NB + 2;
    localparam int LAST = 8 * FL + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  valid;
    logic [N*8-1:0] data;
    logic [N-1:0]  ready;
    logic          b_tick, br_rst, tx, busy;
    logic [1:0]    gid;
    logic [2:0]    bcnt;
    logic          force_tick;

    int n_vec = 0;
    int n_err = 0;

    uart_tx_arbiter #(.N_REQ(N), .DATA_W(8)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (valid),
        .i_req_data  (data),
        .o_req_ready (ready),
        .i_b_tick    (b_tick),
        .o_br_rst    (br_rst),
        .o_tx        (tx),
        .o_busy      (busy),
        .o_grant_id  (gid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (br_rst) bcnt <= 3'd0;
        else        bcnt <= bcnt + 3'd1;
    end
    assign b_tick = (bcnt == 3'd7) | force_tick;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level reference model.
    int       m_ptr = N - 1;
    int       m_gid = 0;
    bit       m_active = 1'b0;
    int       m_off = 0;
    logic     fb [0:10];
    logic     e_tx, e_busy, e_br;
    logic [N-1:0] e_rdy;
    bit       found;
    int       gk, kk;
    logic [7:0] mbyte;
    logic [N-1:0] rdy_s = '0;
    int       grants_q[$];
    logic     tick_q[$];

    always @(negedge clk) begin
        rdy_s = ready;
        for (int k = 0; k < N; k++) if (ready[k]) grants_q.push_back(k);
        if (rst_n && b_tick && !br_rst) tick_q.push_back(tx);

        found = 1'b0;
        gk    = 0;
        e_rdy = '0;
        if (!rst_n) begin
            m_active = 1'b0;
            m_ptr    = N - 1;
            m_gid    = 0;
            e_tx = 1'b1; e_busy = 1'b0; e_br = 1'b1;
        end else begin
            if (m_active && m_off == LAST) m_active = 1'b0;
            if (m_active) begin
                m_off++;
                e_busy = 1'b1;
                if (m_off == 1) begin
                    e_tx = 1'b0; e_br = 1'b1;
                end else begin
                    e_tx = fb[(m_off - 2) / 8]; e_br = 1'b0;
                end
            end else begin
                e_tx = 1'b1; e_busy = 1'b0; e_br = 1'b1;
                for (int i = 1; i <= N; i++) begin
                    kk = (m_ptr + i) % N;
                    if (!found && valid[kk]) begin found = 1'b1; gk = kk; end
                end
                if (found) e_rdy[gk] = 1'b1;
            end
        end

        check("tx",       tx,    e_tx);
        check("busy",     busy,  e_busy);
        check("br_rst",   br_rst, e_br);
        check("ready",    ready, e_rdy);
        check("grant_id", gid,   m_gid);

        if (rst_n && found) begin
            mbyte = data[gk*8 +: 8];
            fb[0] = 1'b0;
            for (int j = 0; j < 8; j++) fb[j+1] = mbyte[j];
`ifdef UART_TX_ARB_PARITY_EN
            fb[9] = ^mbyte;
`endif
            fb[FL-1] = 1'b1;
            m_ptr    = gk;
            m_gid    = gk;
            m_active = 1'b1;
            m_off    = 0;
        end
    end

    logic [N-1:0] hold = '0;
    bit           rnd = 1'b0;

    task automatic cycle();
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (rdy_s[k]) begin
                if (hold[k]) data[k*8 +: 8] = 8'($urandom);
                else         valid[k] = 1'b0;
            end
        end
        if (rnd) begin
            for (int k = 0; k < N; k++) begin
                if (!valid[k] && $urandom_range(0, 15) == 0) begin
                    data[k*8 +: 8] = 8'($urandom);
                    valid[k] = 1'b1;
                end else if (valid[k] && !hold[k] && $urandom_range(0, 63) == 0) begin
                    valid[k] = 1'b0;
                end
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        valid = '0;
        hold  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_quiet(input int budget);
        int c = 0;
        while ((valid != 0 || m_active) && c < budget) begin
            cycle();
            c++;
        end
        check("quiet_in_budget", (valid != 0 || m_active) ? 1 : 0, 0);
    endtask

    task automatic wait_grants(input int n, input int budget);
        int c = 0;
        while (grants_q.size() < n && c < budget) begin
            cycle();
            c++;
        end
        check("grants_in_budget", (grants_q.size() >= n) ? 1 : 0, 1);
    endtask

    int seq_a5 [0:10];
    int c;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        valid = '0; data = '0; force_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx",     tx,     1);
        check("rst_busy",   busy,   0);
        check("rst_br_rst", br_rst, 1);
        check("rst_ready",  ready,  0);
        check("rst_gid",    gid,    0);
        rst_n = 1'b1;

        // Single byte 8'hA5 from requester 0.
`ifdef UART_TX_ARB_PARITY_EN
        seq_a5 = '{0,1,0,1,0,0,1,0,1,0,1};
`else
        seq_a5 = '{0,1,0,1,0,0,1,0,1,1,0};
`endif
        grants_q.delete(); tick_q.delete();
        data[7:0] = 8'hA5; valid[0] = 1'b1;
        wait_quiet(300);
        check("a5_len", tick_q.size(), FL);
        for (int j = 0; j < FL; j++)
            check("a5_bit", (j < tick_q.size()) ? tick_q[j] : 1'bx, seq_a5[j]);
        check("a5_gid", (grants_q.size() > 0) ? grants_q[0] : 99, 0);

        // All four requesters after reset: served in order 0..3.
        do_reset();
        grants_q.delete();
        data = 32'h44332211; valid = 4'hF;
        wait_quiet(2000);
        check("rr4_count", grants_q.size(), 4);
        for (int j = 0; j < 4; j++)
            check("rr4_order", (j < grants_q.size()) ? grants_q[j] : 99, j);

        // Requesters 1 and 3 held continuously: alternate.
        do_reset();
        grants_q.delete();
        data = $urandom; hold = 4'b1010; valid = 4'b1010;
        wait_grants(4, 1000);
        hold = '0;
        wait_quiet(1000);
        for (int j = 0; j < 4; j++)
            check("alt_order", (j < grants_q.size()) ? grants_q[j] : 99, (j % 2 == 0) ? 1 : 3);
        for (int j = 1; j < grants_q.size(); j++)
            check("alt_no_repeat", (grants_q[j] == grants_q[j-1]) ? 1 : 0, 0);

        // Reset during data bit 4 (bit4 of 8'hEF is 0, so the line visibly rises).
        do_reset();
        data[7:0] = 8'hEF; valid[0] = 1'b1;
        c = 0;
        while (!(m_active && m_off >= 44) && c < 200) begin cycle(); c++; end
        check("mid_reached", (m_active && m_off >= 44) ? 1 : 0, 1);
        check("mid_tx_low", tx, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx",     tx,     1);
        check("mid_rst_busy",   busy,   0);
        check("mid_rst_br_rst", br_rst, 1);
        valid = 4'b0100; data[23:16] = 8'h5A;
        repeat (2) @(posedge clk);
        #1;
        grants_q.delete(); tick_q.delete();
        rst_n = 1'b1;
        wait_quiet(300);
        check("post_rst_count", grants_q.size(), 1);
        check("post_rst_gid",   (grants_q.size() > 0) ? grants_q[0] : 99, 2);
        check("post_rst_len",   tick_q.size(), FL);
        do_reset();
        grants_q.delete();
        valid = 4'b0101;
        wait_quiet(600);
        check("ptr_restart", (grants_q.size() > 0) ? grants_q[0] : 99, 0);

        // Tick forced high while in SYNC must not shorten the start bit.
        grants_q.delete(); tick_q.delete();
        data[15:8] = 8'h3C; valid[1] = 1'b1;
        c = 0;
        while (grants_q.size() == 0 && c < 100) begin cycle(); c++; end
        force_tick = 1'b1;
        @(posedge clk);
        #1;
        force_tick = 1'b0;
        wait_quiet(300);
        check("sync_tick_len", tick_q.size(), FL);
        check("sync_tick_start", (tick_q.size() > 0) ? tick_q[0] : 1'bx, 0);

`ifdef UART_TX_ARB_PARITY_EN
        tick_q.delete();
        data[31:24] = 8'h07; valid[3] = 1'b1;
        wait_quiet(300);
        check("par07_len", tick_q.size(), 11);
        check("par07_bit", (tick_q.size() > 9) ? tick_q[9] : 1'bx, 1);
        tick_q.delete();
        data[31:24] = 8'h03; valid[3] = 1'b1;
        wait_quiet(300);
        check("par03_bit", (tick_q.size() > 9) ? tick_q[9] : 1'bx, 0);
`endif

        // Randomised traffic against the model.
        hold = 4'($urandom);
        rnd  = 1'b1;
        repeat (1500) cycle();
        hold = 4'($urandom);
        repeat (1500) cycle();
        rnd  = 1'b0;
        hold = '0;
        wait_quiet(3000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
